// File: rtl/instr_decode_queue.sv
// ---------------------------------------------------------------------------
// instr_decode_queue
//   Buffered MIPS instruction decoder placed between fetch and execute.
//   Each instruction is decoded combinationally when it is pushed, and the
//   decoded entry is stored in a DEPTH-slot FIFO. Entries are presented to the
//   execute stage over a valid/ready handshake. A synchronous flush drops all
//   queued work on a redirect.
//
//   Optional feature (compile-time macro INSTR_DECODE_ILLEGAL_EN):
//     adds out_illegal, which flags opcodes and R-type func codes that are
//     not supported. An illegal entry never writes a register.
//
// Parameters:
//   DATA_W : width of the PC, the extended immediate and the branch target (>= 32)
//   DEPTH  : number of FIFO slots (power of two, >= 2)
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   flush                 synchronous clear of the queue
//   in_valid/in_ready     fetch-side handshake
//   in_instr, in_pc       raw instruction and its address
//   out_valid/out_ready   execute-side handshake
//   out_opcode..out_func  raw fields of the head instruction
//   out_address           26-bit jump index field
//   out_fmt               00 R, 01 I, 10 J
//   out_imm_ext           extended immediate
//   out_br_target         pc + 4 + (sext(imm) << 2)
//   out_wreg, out_we      destination register and write enable
//   out_pc                PC of the head entry
//   level                 number of occupied slots
//   out_illegal           (INSTR_DECODE_ILLEGAL_EN only) unsupported encoding
// ---------------------------------------------------------------------------
module instr_decode_queue #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_instr,
   input  logic [DATA_W-1:0]        in_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [5:0]               out_opcode,
   output logic [4:0]               out_rs,
   output logic [4:0]               out_rt,
   output logic [4:0]               out_rd,
   output logic [4:0]               out_shamt,
   output logic [5:0]               out_func,
   output logic [25:0]              out_address,
   output logic [1:0]               out_fmt,
   output logic [DATA_W-1:0]        out_imm_ext,
   output logic [DATA_W-1:0]        out_br_target,
   output logic [4:0]               out_wreg,
   output logic                     out_we,
   output logic [DATA_W-1:0]        out_pc,
   output logic [$clog2(DEPTH):0]   level
`ifdef INSTR_DECODE_ILLEGAL_EN
   ,
   output logic                     out_illegal
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef struct packed {
      logic [31:0]       instr;
      logic [1:0]        fmt;
      logic [DATA_W-1:0] imm_ext;
      logic [DATA_W-1:0] br_target;
      logic [4:0]        wreg;
      logic              we;
      logic [DATA_W-1:0] pc;
`ifdef INSTR_DECODE_ILLEGAL_EN
      logic              illegal;
`endif
   } entry_t;

   // ------------------------------------------------------------------------
   // Decode of the incoming instruction
   // ------------------------------------------------------------------------
   logic [5:0]        w_op;
   logic [5:0]        w_func;
   logic [15:0]       w_imm;
   logic [DATA_W-1:0] w_sext;
   entry_t            w_dec;

   assign w_op   = in_instr[31:26];
   assign w_func = in_instr[5:0];
   assign w_imm  = in_instr[15:0];
   assign w_sext = {{(DATA_W-16){w_imm[15]}}, w_imm};

   always_comb begin
      w_dec       = '0;
      w_dec.instr = in_instr;
      w_dec.pc    = in_pc;

      case (w_op)
         6'h00:        w_dec.fmt = 2'b00;
         6'h02, 6'h03: w_dec.fmt = 2'b10;
         default:      w_dec.fmt = 2'b01;
      endcase

      // Logical immediates zero-extend; lui places imm in bits [31:16].
      case (w_op)
         6'h0C, 6'h0D, 6'h0E: w_dec.imm_ext[15:0]  = w_imm;
         6'h0F:               w_dec.imm_ext[31:16] = w_imm;
         default:             w_dec.imm_ext        = w_sext;
      endcase

      // Computed for every entry; overflow wraps modulo 2^DATA_W.
      w_dec.br_target = in_pc + DATA_W'(4) + (w_sext << 2);

      case (w_op)
         6'h00: begin
            w_dec.wreg = in_instr[15:11];
            w_dec.we   = 1'b1;
         end
         6'h03: begin
            w_dec.wreg = 5'd31;
            w_dec.we   = 1'b1;
         end
         6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23: begin
            w_dec.wreg = in_instr[20:16];
            w_dec.we   = 1'b1;
         end
         default: begin
            w_dec.wreg = 5'd0;
            w_dec.we   = 1'b0;
         end
      endcase

`ifdef INSTR_DECODE_ILLEGAL_EN
      w_dec.illegal =
         !(w_op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, [6'h08:6'h0F], 6'h23, 6'h2B}) ||
         ((w_op == 6'h00) &&
          !(w_func inside {6'h00, 6'h02, 6'h08, [6'h20:6'h27], 6'h2A, 6'h2B}));
      if (w_dec.illegal) w_dec.we = 1'b0;
`endif

      // Writes to $zero are architecturally discarded.
      if (w_dec.wreg == 5'd0) w_dec.we = 1'b0;
   end

   // ------------------------------------------------------------------------
   // FIFO storage and control
   // ------------------------------------------------------------------------
   entry_t          r_mem [DEPTH];
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_rptr;
   logic [LW-1:0]   r_level;
   logic            w_push;
   logic            w_pop;
   entry_t          w_head;

   // Full blocks a push even if a pop happens in the same cycle.
   assign in_ready  = (r_level != LW'(DEPTH));
   assign out_valid = (r_level != '0);
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;
   assign level     = r_level;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else if (flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Slot contents need no reset: they are only visible while occupied.
   always_ff @(posedge clk) begin
      if (w_push && !flush) r_mem[r_wptr] <= w_dec;
   end

   // ------------------------------------------------------------------------
   // Head presentation, forced to zero while empty
   // ------------------------------------------------------------------------
   assign w_head = out_valid ? r_mem[r_rptr] : '0;

   assign out_opcode    = w_head.instr[31:26];
   assign out_rs        = w_head.instr[25:21];
   assign out_rt        = w_head.instr[20:16];
   assign out_rd        = w_head.instr[15:11];
   assign out_shamt     = w_head.instr[10:6];
   assign out_func      = w_head.instr[5:0];
   assign out_address   = w_head.instr[25:0];
   assign out_fmt       = w_head.fmt;
   assign out_imm_ext   = w_head.imm_ext;
   assign out_br_target = w_head.br_target;
   assign out_wreg      = w_head.wreg;
   assign out_we        = w_head.we;
   assign out_pc        = w_head.pc;
`ifdef INSTR_DECODE_ILLEGAL_EN
   assign out_illegal   = w_head.illegal;
`endif

endmodule

// File: tb/tb_instr_decode_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_decode_queue
//   Self-checking bench for instr_decode_queue: a table of known encodings,
//   hand sequences for full / wrap / flush / async reset, and a randomized
//   run checked against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_instr_decode_queue;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;
   localparam int LW     = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0]       in_instr;
   logic [DATA_W-1:0] in_pc;
   logic [5:0]        out_opcode, out_func;
   logic [4:0]        out_rs, out_rt, out_rd, out_shamt, out_wreg;
   logic [25:0]       out_address;
   logic [1:0]        out_fmt;
   logic [DATA_W-1:0] out_imm_ext, out_br_target, out_pc;
   logic              out_we;
   logic [LW-1:0]     level;
`ifdef INSTR_DECODE_ILLEGAL_EN
   logic              out_illegal;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   instr_decode_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
      .out_shamt(out_shamt), .out_func(out_func), .out_address(out_address),
      .out_fmt(out_fmt), .out_imm_ext(out_imm_ext), .out_br_target(out_br_target),
      .out_wreg(out_wreg), .out_we(out_we), .out_pc(out_pc), .level(level)
`ifdef INSTR_DECODE_ILLEGAL_EN
      , .out_illegal(out_illegal)
`endif
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model (spec rules, plain arithmetic) ----------
   typedef struct {
      logic [1:0]  fmt;
      logic [31:0] imm;
      logic [31:0] br;
      logic [4:0]  wreg;
      logic        we;
      logic        ill;
   } exp_t;

   function automatic exp_t ref_dec(input logic [31:0] instr, input logic [31:0] pc);
      exp_t   e;
      int     op, fn, rt, rd, imm16;
      longint sx;
      op    = int'(instr >> 26);
      fn    = int'(instr % 64);
      rt    = int'((instr >> 16) % 32);
      rd    = int'((instr >> 11) % 32);
      imm16 = int'(instr % 65536);
      sx    = (imm16 >= 32768) ? longint'(imm16) - 65536 : longint'(imm16);
      e.fmt = (op == 0) ? 2'd0 : ((op == 2 || op == 3) ? 2'd2 : 2'd1);
      if (op >= 12 && op <= 14)  e.imm = 32'(imm16);
      else if (op == 15)         e.imm = 32'(longint'(imm16) * 65536);
      else                       e.imm = 32'(sx);
      e.br = 32'(longint'(pc) + 4 + sx * 4);
      if (op == 0)                              e.wreg = 5'(rd);
      else if (op == 3)                         e.wreg = 5'd31;
      else if ((op >= 8 && op <= 15) || op == 35) e.wreg = 5'(rt);
      else                                      e.wreg = 5'd0;
      e.ill = 1'b0;
`ifdef INSTR_DECODE_ILLEGAL_EN
      e.ill = !(op inside {0, 2, 3, 4, 5, 8, 9, 10, 11, 12, 13, 14, 15, 35, 43}) ||
              (op == 0 && !(fn inside {0, 2, 8, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43}));
`endif
      e.we = (e.wreg != 0) && !e.ill;
      return e;
   endfunction

   task automatic check_head(input string tag, input logic [31:0] instr, input logic [31:0] pc);
      exp_t e;
      e = ref_dec(instr, pc);
      chk({tag, ".valid"},  64'(out_valid),     64'd1);
      chk({tag, ".opcode"}, 64'(out_opcode),    64'(instr >> 26));
      chk({tag, ".rs"},     64'(out_rs),        64'((instr >> 21) % 32));
      chk({tag, ".rt"},     64'(out_rt),        64'((instr >> 16) % 32));
      chk({tag, ".rd"},     64'(out_rd),        64'((instr >> 11) % 32));
      chk({tag, ".shamt"},  64'(out_shamt),     64'((instr >> 6) % 32));
      chk({tag, ".func"},   64'(out_func),      64'(instr % 64));
      chk({tag, ".addr"},   64'(out_address),   64'(instr % (1 << 26)));
      chk({tag, ".fmt"},    64'(out_fmt),       64'(e.fmt));
      chk({tag, ".imm"},    64'(out_imm_ext),   64'(e.imm));
      chk({tag, ".br"},     64'(out_br_target), 64'(e.br));
      chk({tag, ".wreg"},   64'(out_wreg),      64'(e.wreg));
      chk({tag, ".we"},     64'(out_we),        64'(e.we));
      chk({tag, ".pc"},     64'(out_pc),        64'(pc));
`ifdef INSTR_DECODE_ILLEGAL_EN
      chk({tag, ".ill"},    64'(out_illegal),   64'(e.ill));
`endif
   endtask

   // ---------------- table of hand-derived vectors ---------------------------
   typedef struct {
      string       nm;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [1:0]  fmt;
      logic [31:0] imm;
      logic [31:0] br;
      logic [4:0]  wreg;
      logic        we;
   } vec_t;

   vec_t vt[8];

   task automatic push1(input logic [31:0] instr, input logic [31:0] pc);
      in_valid = 1'b1; in_instr = instr; in_pc = pc;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pop1();
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      out_ready = 1'b0;
   endtask

   logic [31:0] q_instr[$];
   logic [31:0] q_pc[$];

   initial begin
      vt[0] = '{"addi", 32'h2128FFFC, 32'h00400000, 2'b01, 32'hFFFFFFFC, 32'h003FFFF4, 5'd8,  1'b1};
      vt[1] = '{"ori",  32'h35288000, 32'h00000000, 2'b01, 32'h00008000, 32'hFFFE0004, 5'd8,  1'b1};
      vt[2] = '{"lui",  32'h3C011234, 32'h00000000, 2'b01, 32'h12340000, 32'h000048D4, 5'd1,  1'b1};
      vt[3] = '{"add",  32'h01095020, 32'h00000100, 2'b00, 32'h00005020, 32'h00014184, 5'd10, 1'b1};
      vt[4] = '{"jal",  32'h0C000010, 32'h00000000, 2'b10, 32'h00000010, 32'h00000044, 5'd31, 1'b1};
      vt[5] = '{"beq",  32'h11090003, 32'h00400000, 2'b01, 32'h00000003, 32'h00400010, 5'd0,  1'b0};
      vt[6] = '{"sw",   32'hAD280004, 32'h00000000, 2'b01, 32'h00000004, 32'h00000014, 5'd0,  1'b0};
      vt[7] = '{"nop",  32'h00000000, 32'h00000000, 2'b00, 32'h00000000, 32'h00000004, 5'd0,  1'b0};

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_pc = '0;
      repeat (2) @(negedge clk);
      chk("rst.level", 64'(level), 64'd0);
      chk("rst.valid", 64'(out_valid), 64'd0);
      chk("rst.ready", 64'(in_ready), 64'd1);
      chk("rst.imm",   64'(out_imm_ext), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // ---- table ----
      for (int i = 0; i < 8; i++) begin
         push1(vt[i].instr, vt[i].pc);
         chk({vt[i].nm, ".valid"}, 64'(out_valid),     64'd1);
         chk({vt[i].nm, ".fmt"},   64'(out_fmt),       64'(vt[i].fmt));
         chk({vt[i].nm, ".imm"},   64'(out_imm_ext),   64'(vt[i].imm));
         chk({vt[i].nm, ".br"},    64'(out_br_target), 64'(vt[i].br));
         chk({vt[i].nm, ".wreg"},  64'(out_wreg),      64'(vt[i].wreg));
         chk({vt[i].nm, ".we"},    64'(out_we),        64'(vt[i].we));
         chk({vt[i].nm, ".rs"},    64'(out_rs),        64'(vt[i].instr[25:21]));
         chk({vt[i].nm, ".rd"},    64'(out_rd),        64'(vt[i].instr[15:11]));
         chk({vt[i].nm, ".func"},  64'(out_func),      64'(vt[i].instr[5:0]));
         chk({vt[i].nm, ".addr"},  64'(out_address),   64'(vt[i].instr[25:0]));
         pop1();
         chk({vt[i].nm, ".empty"}, 64'(out_valid),     64'd0);
      end

`ifdef INSTR_DECODE_ILLEGAL_EN
      push1(32'hFC000000, 32'h0);
      chk("ill.flag", 64'(out_illegal), 64'd1);
      chk("ill.we",   64'(out_we),      64'd0);
      push1(32'h01095020, 32'h0);
      pop1();
      chk("ill.add",  64'(out_illegal), 64'd0);
      pop1();
`endif

      // ---- full queue, no push-through, FIFO order across wrap ----
      for (int k = 0; k < DEPTH; k++) begin
         in_valid = 1'b1; in_instr = 32'h01095020; in_pc = 32'h1000 + 32'(4 * k);
         @(posedge clk); @(negedge clk);
      end
      chk("full.ready", 64'(in_ready), 64'd0);
      chk("full.level", 64'(level),    64'(DEPTH));
      in_pc = 32'hDEAD;
      @(posedge clk); @(negedge clk);
      chk("full.ignore", 64'(level), 64'(DEPTH));
      in_pc = 32'h2000; out_ready = 1'b1;
      chk("wrap.head0", 64'(out_pc), 64'h1000);
      @(posedge clk); @(negedge clk);
      chk("wrap.pop_only", 64'(level), 64'(DEPTH - 1));
      chk("wrap.head1", 64'(out_pc), 64'h1004);
      @(posedge clk); @(negedge clk);
      chk("wrap.pushpop", 64'(level), 64'(DEPTH - 1));
      in_valid = 1'b0;
      for (int k = 0; k < DEPTH - 1; k++) begin
         chk("wrap.order", 64'(out_pc), (k == DEPTH - 2) ? 64'h2000 : 64'(32'h1008 + 32'(4 * k)));
         @(posedge clk); @(negedge clk);
      end
      out_ready = 1'b0;
      chk("wrap.empty", 64'(out_valid), 64'd0);

      // ---- flush beats a simultaneous push ----
      for (int k = 0; k < 3; k++) push1(32'h2128FFFC, 32'(k));
      chk("flush.pre", 64'(level), 64'd3);
      flush = 1'b1; in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      chk("flush.level", 64'(level),     64'd0);
      chk("flush.valid", 64'(out_valid), 64'd0);
      chk("flush.pc",    64'(out_pc),    64'd0);

      // ---- asynchronous reset mid-stream ----
      push1(32'h2128FFFC, 32'h40);
      push1(32'h2128FFFC, 32'h44);
      #2 rst_n = 1'b0;
      #1;
      chk("arst.valid", 64'(out_valid), 64'd0);
      chk("arst.level", 64'(level),     64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // ---- randomized run against queue model ----
      for (int c = 0; c < 400; c++) begin
         logic vin, ordy, fl, push_ok, pop_ok;
         logic [31:0] ri;
         int opsel;
         chk("rnd.level", 64'(level),    64'(q_instr.size()));
         chk("rnd.ready", 64'(in_ready), 64'(q_instr.size() != DEPTH));
         if (q_instr.size() != 0) check_head("rnd", q_instr[0], q_pc[0]);
         else chk("rnd.valid", 64'(out_valid), 64'd0);

         vin  = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 2) != 0);
         fl   = ($urandom_range(0, 29) == 0);
         ri   = $urandom;
         opsel = $urandom_range(0, 7);
         case (opsel)
            0: ri[31:26] = 6'h00;
            1: ri[31:26] = 6'($urandom_range(2, 5));
            2, 3: ri[31:26] = 6'($urandom_range(8, 15));
            4: ri[31:26] = 6'h23;
            5: ri[31:26] = 6'h2B;
            default: ;
         endcase
         in_valid = vin; out_ready = ordy; flush = fl;
         in_instr = ri;  in_pc = $urandom;
         push_ok = vin && (q_instr.size() != DEPTH);
         pop_ok  = ordy && (q_instr.size() != 0);
         @(posedge clk);
         if (fl) begin
            q_instr.delete(); q_pc.delete();
         end else begin
            if (pop_ok)  begin void'(q_instr.pop_front()); void'(q_pc.pop_front()); end
            if (push_ok) begin q_instr.push_back(ri); q_pc.push_back(in_pc); end
         end
         @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/instr_decode_queue.md
Name: instr_decode_queue

Overview:
- Parametrised, buffered successor to the combinational field splitter.
- Accepts 32-bit MIPS instructions with their PC over a valid/ready handshake and decodes them into fields, format class, extended immediate, branch target and destination register.
- Stores decoded entries in a DEPTH-entry FIFO and presents them to the execute stage over a second valid/ready handshake.
- Sits between fetch and execute; a synchronous flush discards queued work on redirect.

Parameters:
- DATA_W, 32, width of PC, extended immediate and branch target; must be >= 32.
- DEPTH, 4, number of decoded-entry slots; power of two, >= 2.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous queue clear
- in_valid  input  1  instruction offered
- in_ready  output  1  queue can accept
- in_instr  input  32  raw instruction
- in_pc  input  DATA_W  instruction address
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer takes head
- out_opcode  output  6  instr[31:26]
- out_rs  output  5  instr[25:21]
- out_rt  output  5  instr[20:16]
- out_rd  output  5  instr[15:11]
- out_shamt  output  5  instr[10:6]
- out_func  output  6  instr[5:0]
- out_address  output  26  instr[25:0]
- out_fmt  output  2  00 R, 01 I, 10 J
- out_imm_ext  output  DATA_W  extended immediate
- out_br_target  output  DATA_W  in_pc + 4 + (sext(imm) << 2), modulo 2^DATA_W
- out_wreg  output  5  destination register
- out_we  output  1  instruction writes a register
- out_pc  output  DATA_W  PC of head entry
- level  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async, rst_n=0): queue empty; level=0; out_valid=0; in_ready=1. All data outputs are 0 while empty.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (level != DEPTH). There is no push-through when full, even if a pop happens in the same cycle.
- out_valid = (level != 0).
- Decode is combinational on in_instr at push, and the result is stored. Latency is 1 cycle: a push into an empty queue gives out_valid=1 on the next cycle.
- Simultaneous push and pop when 0 < level < DEPTH: level is unchanged and head advances.
- fmt: opcode 0x00 gives R; 0x02 and 0x03 give J; all other opcodes give I.
- imm_ext:
  - andi/ori/xori (0x0C/0x0D/0x0E): zero-extend.
  - lui (0x0F): {imm,16'h0}, zero-extended to DATA_W.
  - Otherwise: sign-extend from bit 15.
- wreg/we:
  - R-type: rd, we=1.
  - jal (0x03): 31, we=1.
  - addi/addiu/slti/sltiu/andi/ori/xori/lui/lw (0x08–0x0F, 0x23): rt, we=1.
  - Otherwise: wreg=0, we=0.
  - Any wreg of 0 forces we=0.
- br_target is computed for every entry regardless of opcode.
- Pointers wrap modulo DEPTH.
- flush=1: level goes to 0 and pointers to 0 next cycle; out_valid=0. flush beats any simultaneous push or pop; a push in the flush cycle is discarded.
- Reset asserted mid-operation clears the queue immediately, without waiting for a clock edge.

Optional Feature:
- Macro: INSTR_DECODE_ILLEGAL_EN.
- Defined:
  - Adds output out_illegal (1 bit) per entry.
  - out_illegal=1 when opcode is not in {0x00,0x02,0x03,0x04,0x05,0x08–0x0F,0x23,0x2B}, or when opcode 0x00 has func not in {0x00,0x02,0x08,0x20–0x27,0x2A,0x2B}.
  - An illegal entry forces we=0.
  - out_illegal resets to 0.
- Not defined: the port is absent and no checking logic exists.

Test Plan:
- Reset, then push 0x2128FFFC (addi) at pc 0x00400000 -> next cycle:
  - out_valid=1, fmt=01, rs=9, rt=8.
  - imm_ext=0xFFFFFFFC, wreg=8, we=1.
  - br_target=0x003FFFF4.
- Push 0x35288000 (ori) -> imm_ext=0x00008000, wreg=8, we=1. Push 0x3C011234 (lui) -> imm_ext=0x12340000, wreg=1.
- Push 0x01095020 (add) -> fmt=00, rd=10, func=0x20, wreg=10, we=1. Push 0x0C000010 (jal) -> fmt=10, address=0x10, wreg=31, we=1.
- Push 0x11090003 (beq) at pc 0x00400000 -> br_target=0x00400010, we=0. Push 0xAD280004 (sw) -> we=0.
- Hold out_ready=0 and push DEPTH entries -> in_ready=0, level=DEPTH; a further in_valid is ignored. Then pop+push together -> level stays DEPTH-1 after the pop-only cycle. Entries drain in FIFO order across the pointer wrap.
- Fill with 3 entries, assert flush together with in_valid -> next cycle level=0, out_valid=0. Assert rst_n=0 mid-stream -> out_valid=0 asynchronously. With INSTR_DECODE_ILLEGAL_EN defined, push 0xFC000000 -> out_illegal=1, we=0.
